// File: rtl/divider_restoring_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional feature macro: DIV_ZERO_CHECK_EN (zero divisor finishes one edge after accept, flags div_zero).
module divider_restoring_seq #(
    parameter int unsigned WIDTH_A = 16,
    parameter int unsigned WIDTH_B = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_A-1:0] dividend,
    input  logic [WIDTH_B-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] quotient,
    output logic [WIDTH_B-1:0] remainder,
    output logic               div_zero
);

    localparam int unsigned CNT_W = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;
    localparam int unsigned REM_W = WIDTH_B + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH_A - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH_A-1:0]   r_q;
    logic [WIDTH_B-1:0]   r_rem;
    logic [WIDTH_B-1:0]   r_dsr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH_A-1:0]   r_quot;
    logic [WIDTH_B-1:0]   r_remo;

    logic                 w_accept;
    logic [REM_W-1:0]     w_shift;
    logic                 w_ge;
    logic [WIDTH_B-1:0]   w_rem_nxt;
    logic [WIDTH_A-1:0]   w_q_nxt;
    logic                 w_last;
    logic                 w_byp;

`ifdef DIV_ZERO_CHECK_EN
    logic                 r_byp;
    logic                 r_dz;

    assign w_byp    = r_byp;
    assign div_zero = r_dz;
`else
    assign w_byp    = 1'b0;
    assign div_zero = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_remo;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus one restoring iteration; r_q shifts dividend out and quotient in
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = {r_rem, r_q[WIDTH_A-1]};
        w_ge        = (w_shift >= {1'b0, r_dsr});
        w_rem_nxt   = w_ge ? (w_shift[WIDTH_B-1:0] - r_dsr) : w_shift[WIDTH_B-1:0];
        w_q_nxt     = {r_q[WIDTH_A-2:0], w_ge};
        w_last      = (r_cnt == LAST_ITER) || w_byp;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_quot <= '0;
            r_remo <= '0;
`ifdef DIV_ZERO_CHECK_EN
            r_byp  <= 1'b0;
            r_dz   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_busy <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
            if (w_accept) begin
                r_q   <= dividend;
                r_dsr <= divisor;
                r_rem <= '0;
                r_cnt <= '0;
`ifdef DIV_ZERO_CHECK_EN
                r_byp <= (divisor == '0);
`endif
            end else if (r_state == S_RUN) begin
                if (w_last) begin
                    r_done <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    r_dz   <= r_byp;
                    if (r_byp) begin
                        r_quot <= {WIDTH_A{1'b1}};
                        r_remo <= r_q[WIDTH_B-1:0];
                    end else begin
                        r_quot <= w_q_nxt;
                        r_remo <= w_rem_nxt;
                    end
`else
                    r_quot <= w_q_nxt;
                    r_remo <= w_rem_nxt;
`endif
                end else begin
                    r_q   <= w_q_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Directed and randomized self-checking bench for divider_restoring_seq.
// Honors DIV_ZERO_CHECK_EN when compiled with it.
module tb_divider_restoring_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

`ifdef DIV_ZERO_CHECK_EN
    localparam int ZERO_LAT = 1;
    localparam bit ZERO_DZ  = 1'b1;
`else
    localparam int ZERO_LAT = 16;
    localparam bit ZERO_DZ  = 1'b0;
`endif

    divider_restoring_seq #(.WIDTH_A(16), .WIDTH_B(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from an IDLE/DONE cycle; return edges until done and busy cycles seen
    task automatic do_op(input logic [15:0] a, input logic [7:0] d,
                         output int lat, output int bsy);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        bsy = 0;
        if (busy) bsy++;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bsy++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bsy;
        do_op(16'd1000, 8'd7, lat, bsy);
        checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got=%0d exp=16", lat); end
        checks++; if (quotient !== 16'd142) begin errors++; $display("FAIL basic_q got=%0d exp=142", quotient); end
        checks++; if (remainder !== 8'd6) begin errors++; $display("FAIL basic_r got=%0d exp=6", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b exp=0", div_zero); end
        checks++; if (bsy !== 15) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=15", bsy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (quotient !== 16'd142) begin errors++; $display("FAIL basic_q_hold got=%0d exp=142", quotient); end
    endtask

    task automatic test_edges();
        logic [15:0] va [4] = '{16'd65535, 16'd0, 16'd255, 16'd100};
        logic [7:0]  vd [4] = '{8'd255,    8'd5,  8'd1,   8'd200};
        logic [15:0] eq [4] = '{16'd257,   16'd0, 16'd255, 16'd0};
        logic [7:0]  er [4] = '{8'd0,      8'd0,  8'd0,   8'd100};
        int lat, bsy;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vd[i], lat, bsy);
            checks++; if (lat !== 16) begin errors++; $display("FAIL edge%0d_latency got=%0d exp=16", i, lat); end
            checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL edge%0d_q got=%0d exp=%0d", i, quotient, eq[i]); end
            checks++; if (remainder !== er[i]) begin errors++; $display("FAIL edge%0d_r got=%0d exp=%0d", i, remainder, er[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat, bsy;
        do_op(16'd35, 8'd0, lat, bsy);
        checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL dz_latency got=%0d exp=%0d", lat, ZERO_LAT); end
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_q got=%h exp=ffff", quotient); end
        checks++; if (remainder !== 8'd35) begin errors++; $display("FAIL dz_r got=%0d exp=35", remainder); end
        checks++; if (div_zero !== ZERO_DZ) begin errors++; $display("FAIL dz_flag got=%b exp=%b", div_zero, ZERO_DZ); end
        do_op(16'd100, 8'd7, lat, bsy);
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
        checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL dz_after_q got=%0d exp=14", quotient); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int first = -1;
        logic [15:0] q_seen = '0;
        logic [7:0]  r_seen = '0;
        dividend = 16'd5000;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 5) begin
                start = 1'b1; dividend = 16'd3; divisor = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) begin first = e; q_seen = quotient; r_seen = remainder; end
            end
        end
        start = 1'b0;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (first !== 16) begin errors++; $display("FAIL ignore_latency got=%0d exp=16", first); end
        checks++; if (q_seen !== 16'd555) begin errors++; $display("FAIL ignore_q got=%0d exp=555", q_seen); end
        checks++; if (r_seen !== 8'd5) begin errors++; $display("FAIL ignore_r got=%0d exp=5", r_seen); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int lat, bsy;
        dividend = 16'd1234;
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL abort_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL abort_r got=%0d exp=0", remainder); end
        rst = 1'b0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        do_op(16'd1234, 8'd10, lat, bsy);
        checks++; if (lat !== 16) begin errors++; $display("FAIL abort_rerun_latency got=%0d exp=16", lat); end
        checks++; if (quotient !== 16'd123) begin errors++; $display("FAIL abort_rerun_q got=%0d exp=123", quotient); end
        checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL abort_rerun_r got=%0d exp=4", remainder); end
    endtask

    task automatic test_back_to_back();
        int lat, bsy, exp_lat;
        logic [15:0] a, exp_q;
        logic [7:0]  d, exp_r;
        logic        exp_dz;
        for (int n = 0; n < 2000; n++) begin
            a = 16'($urandom);
            d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (d == 8'd0) begin
                exp_q = 16'hFFFF; exp_r = a[7:0]; exp_lat = ZERO_LAT; exp_dz = ZERO_DZ;
            end else begin
                exp_q = a / 16'(d); exp_r = 8'(a % 16'(d)); exp_lat = 16; exp_dz = 1'b0;
            end
            do_op(a, d, lat, bsy);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", n, lat, exp_lat); end
            checks++; if (quotient !== exp_q || remainder !== exp_r) begin
                errors++; $display("FAIL b2b%0d_qr a=%0d d=%0d got=%0d/%0d exp=%0d/%0d", n, a, d, quotient, remainder, exp_q, exp_r);
            end
            checks++; if (div_zero !== exp_dz) begin errors++; $display("FAIL b2b%0d_dz got=%b exp=%b", n, div_zero, exp_dz); end
            if (d != 8'd0) begin
                checks++;
                if ((32'(quotient) * 32'(d) + 32'(remainder)) !== 32'(a) || remainder >= d) begin
                    errors++; $display("FAIL b2b%0d_invariant a=%0d d=%0d q=%0d r=%0d", n, a, d, quotient, remainder);
                end
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_final_done got=%b exp=0", done); end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
